// File: rtl/ps2_digit_decoder.sv
// Scan-code set 2 decoder feeding a four-digit, right-entering display buffer.
// Define KEY_REPEAT_EN to accept typematic repeats of digits and Backspace.
module ps2_digit_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [3:0] Data0,
  output logic [3:0] Data1,
  output logic [3:0] Data2,
  output logic [3:0] Data3,
  output logic [2:0] digit_count,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam logic [7:0]  CODE_EXT  = 8'hE0;
  localparam logic [7:0]  CODE_BRK  = 8'hF0;
  localparam logic [7:0]  CODE_BKSP = 8'h66;
  localparam logic [7:0]  CODE_ESC  = 8'h76;
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt, tmo_nxt;
  logic [7:0]  last_make;
  logic        held;
  logic        make_evt, brk_evt, is_repeat, accept;
  logic        is_digit;
  logic [3:0]  digit_val;

  // Main-row and keypad codes both map to the same decimal digit
  always_comb begin
    is_digit  = 1'b1;
    digit_val = 4'd0;
    case (rx_byte)
      8'h45, 8'h70: digit_val = 4'd0;
      8'h16, 8'h69: digit_val = 4'd1;
      8'h1E, 8'h72: digit_val = 4'd2;
      8'h26, 8'h7A: digit_val = 4'd3;
      8'h25, 8'h6B: digit_val = 4'd4;
      8'h2E, 8'h73: digit_val = 4'd5;
      8'h36, 8'h74: digit_val = 4'd6;
      8'h3D, 8'h6C: digit_val = 4'd7;
      8'h3E, 8'h75: digit_val = 4'd8;
      8'h46, 8'h7D: digit_val = 4'd9;
      default:      is_digit  = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    tmo_nxt   = 16'd0;
    make_evt  = 1'b0;
    brk_evt   = 1'b0;
    case (state)
      IDLE: if (rx_valid) begin
        if (rx_byte == CODE_EXT)      state_nxt = EXT;
        else if (rx_byte == CODE_BRK) state_nxt = BRK;
        else                          make_evt  = 1'b1;
      end
      BRK: if (rx_valid) begin
        brk_evt   = 1'b1;
        state_nxt = IDLE;
      end
      EXT: if (rx_valid) state_nxt = (rx_byte == CODE_BRK) ? EXT_BRK : IDLE;
      EXT_BRK: if (rx_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A pending prefix is abandoned if its follow-up byte never arrives
    if (state != IDLE && !rx_valid) begin
      if (tmo_cnt == TMO_LAST) state_nxt = IDLE;
      else                     tmo_nxt   = tmo_cnt + 16'd1;
    end
    is_repeat = make_evt && held && (rx_byte == last_make);
`ifdef KEY_REPEAT_EN
    accept = make_evt && (!is_repeat || is_digit || rx_byte == CODE_BKSP);
`else
    accept = make_evt && !is_repeat;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmo_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_make   <= 8'h00;
      held        <= 1'b0;
      Data0       <= 4'hF;
      Data1       <= 4'hF;
      Data2       <= 4'hF;
      Data3       <= 4'hF;
      digit_count <= 3'd0;
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
    end else begin
      key_valid <= 1'b0;
      if (make_evt && !is_repeat) begin
        last_make <= rx_byte;
        held      <= 1'b1;
      end
      if (brk_evt && rx_byte == last_make) held <= 1'b0;
      if (accept) begin
        if (is_digit) begin
          Data3       <= Data2;
          Data2       <= Data1;
          Data1       <= Data0;
          Data0       <= digit_val;
          digit_count <= (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
          key_valid   <= 1'b1;
          key_code    <= digit_val;
        end else if (rx_byte == CODE_BKSP) begin
          if (digit_count != 3'd0) begin
            Data0       <= Data1;
            Data1       <= Data2;
            Data2       <= Data3;
            Data3       <= 4'hF;
            digit_count <= digit_count - 3'd1;
          end
        end else if (rx_byte == CODE_ESC) begin
          Data0       <= 4'hF;
          Data1       <= 4'hF;
          Data2       <= 4'hF;
          Data3       <= 4'hF;
          digit_count <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_digit_decoder.sv
// Randomized scoreboard bench for ps2_digit_decoder against a behavioural keyboard model.
module tb_ps2_digit_decoder;

  localparam int T = 20;
  localparam int P_NONE = 0, P_BRK = 1, P_EXT = 2, P_EXTBRK = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [3:0] Data0, Data1, Data2, Data3;
  logic [2:0] digit_count;
  logic       key_valid;
  logic [3:0] key_code;

  ps2_digit_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .Data0(Data0), .Data1(Data1), .Data2(Data2), .Data3(Data3),
    .digit_count(digit_count), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] disp;
    logic [2:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: disp[0] is the newest digit
  int disp[4];
  int cnt;
  int prefix;
  int last;
  bit held;
  int idle_gap;
  int codes[20] = '{'h45, 'h70, 'h16, 'h69, 'h1E, 'h72, 'h26, 'h7A, 'h25, 'h6B,
                    'h2E, 'h73, 'h36, 'h74, 'h3D, 'h6C, 'h3E, 'h75, 'h46, 'h7D};

  function automatic int digitOf(input int b);
    for (int i = 0; i < 20; i++) if (codes[i] == b) return i / 2;
    return -1;
  endfunction

  function automatic logic [15:0] packDisp();
    return {4'(disp[3]), 4'(disp[2]), 4'(disp[1]), 4'(disp[0])};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) disp[i] = 15;
    cnt = 0; prefix = P_NONE; last = 0; held = 0; idle_gap = 0;
    q.delete();
  endtask

  task automatic actOn(input int b, input int d);
    if (d >= 0) begin
      for (int i = 3; i > 0; i--) disp[i] = disp[i-1];
      disp[0] = d;
      if (cnt < 4) cnt++;
      q.push_back('{code: 4'(d), disp: packDisp(), cnt: 3'(cnt)});
    end else if (b == 'h66) begin
      if (cnt > 0) begin
        for (int i = 0; i < 3; i++) disp[i] = disp[i+1];
        disp[3] = 15;
        cnt--;
      end
    end else if (b == 'h76) begin
      for (int i = 0; i < 4; i++) disp[i] = 15;
      cnt = 0;
    end
  endtask

  task automatic modelMake(input int b);
    int d;
    d = digitOf(b);
    if (held && b == last) begin
`ifdef KEY_REPEAT_EN
      if (d >= 0 || b == 'h66) actOn(b, d);
`endif
      return;
    end
    last = b;
    held = 1;
    actOn(b, d);
  endtask

  task automatic modelByte(input int b);
    if (prefix != P_NONE && idle_gap >= T) prefix = P_NONE;
    case (prefix)
      P_NONE: begin
        if (b == 'hE0)      prefix = P_EXT;
        else if (b == 'hF0) prefix = P_BRK;
        else                modelMake(b);
      end
      P_BRK: begin
        if (b == last) held = 0;
        prefix = P_NONE;
      end
      P_EXT:   prefix = (b == 'hF0) ? P_EXTBRK : P_NONE;
      default: prefix = P_NONE;
    endcase
    idle_gap = 0;
  endtask

  task automatic checkOutput(input string name);
    checks++;
    if ({Data3, Data2, Data1, Data0} != packDisp() || digit_count != 3'(cnt)) begin
      errors++;
      $display("[TB] FAIL %s: got digits=%h count=%0d, want digits=%h count=%0d at %0t",
               name, {Data3, Data2, Data1, Data0}, digit_count, packDisp(), cnt, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput("display");
  endtask

  task automatic applyStimulus(input int b, input int gap);
    repeat (gap) begin
      tick();
      rx_valid = 1'b0;
      idle_gap++;
    end
    tick();
    rx_valid = 1'b1;
    rx_byte  = 8'(b);
    modelByte(b);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      tick();
      rx_valid = 1'b0;
      idle_gap++;
    end
  endtask

  task automatic checkResetState(input string name);
    checkOutput(name);
    checks++;
    if (key_valid !== 1'b0 || key_code !== 4'd0) begin
      errors++;
      $display("[TB] FAIL %s: got key_valid=%b key_code=%h, want 0/0", name, key_valid, key_code);
    end
  endtask

  // Scoreboard monitor: every key_valid pulse must match the oldest expected acceptance
  always @(negedge clk) begin
    exp_t e;
    if (reset && key_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("[TB] FAIL key_valid: got pulse code=%h, want no pulse at %0t", key_code, $time);
      end else begin
        e = q.pop_front();
        if (key_code != e.code || {Data3, Data2, Data1, Data0} != e.disp || digit_count != e.cnt) begin
          errors++;
          $display("[TB] FAIL key_event: got code=%h digits=%h count=%0d, want code=%h digits=%h count=%0d",
                   key_code, {Data3, Data2, Data1, Data0}, digit_count, e.code, e.disp, e.cnt);
        end
      end
    end
  end

  initial begin
    int pool[12] = '{'h16, 'h45, 'h7D, 'h3E, 'h26, 'hF0, 'hE0, 'h66, 'h76, 'hAA, 'h6C, 'h46};
    int b, g;
    reset = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b1;

    // Two digits, each with its break code
    foreach (pool[i]) if (i < 0) b = 0;
    applyStimulus('h16, 2); applyStimulus('hF0, 0); applyStimulus('h16, 0);
    applyStimulus('h1E, 0); applyStimulus('hF0, 0); applyStimulus('h1E, 0);
    idleCycles(2);

    // Typematic repeat without break
    applyStimulus('h26, 0); applyStimulus('h26, 1); applyStimulus('h26, 1);
    applyStimulus('hF0, 1); applyStimulus('h26, 0);
    idleCycles(2);

    // Fill past four digits, then Backspace and Esc
    applyStimulus('h76, 0); applyStimulus('hF0, 0); applyStimulus('h76, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(codes[2*(i+1)], 1); applyStimulus('hF0, 0); applyStimulus(codes[2*(i+1)], 0);
    end
    applyStimulus('h66, 1); applyStimulus('hF0, 0); applyStimulus('h66, 0);
    applyStimulus('h66, 1); applyStimulus('hF0, 0); applyStimulus('h66, 0);
    applyStimulus('h76, 1); applyStimulus('hF0, 0); applyStimulus('h76, 0);
    applyStimulus('h66, 1); applyStimulus('hF0, 0); applyStimulus('h66, 0);
    idleCycles(2);

    // Extended keys never affect digits
    applyStimulus('hE0, 0); applyStimulus('h70, 0);
    applyStimulus('hE0, 0); applyStimulus('hF0, 0); applyStimulus('h70, 0);
    applyStimulus('h70, 1); applyStimulus('hF0, 0); applyStimulus('h70, 0);

    // Prefix timeout: expired prefix versus byte on the exact expiry cycle
    applyStimulus('hF0, 2); applyStimulus('h45, T);
    applyStimulus('hF0, 1); applyStimulus('h45, T - 1);
    applyStimulus('h45, 1);
    applyStimulus('hF0, 0); applyStimulus('h45, 0);
    idleCycles(3);

    // Reset between a break prefix and its follow-up byte
    applyStimulus('hF0, 0);
    tick();
    rx_valid = 1'b0;
    #2 reset = 1'b0;
    modelReset();
    #1 checkResetState("reset_midseq");
    @(negedge clk) reset = 1'b1;
    applyStimulus('h46, 1); applyStimulus('hF0, 0); applyStimulus('h46, 0);
    idleCycles(2);

    // Randomized traffic including gaps around the timeout boundary
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       b = $urandom_range(0, 255);
        1, 2:    b = codes[$urandom_range(0, 19)];
        default: b = pool[$urandom_range(0, 11)];
      endcase
      case ($urandom_range(0, 19))
        0:       g = T - 1;
        1:       g = T;
        default: g = $urandom_range(0, 2);
      endcase
      applyStimulus(b, g);
    end
    idleCycles(5);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_keys: got %0d undelivered, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
